// File: rtl/serial_tx_if.sv
// Load handshake and serial-side outputs of the serial_tx parallel-in/serial-out transmitter.
interface serial_tx_if #(
  parameter int WIDTH = 4
);
  logic             load_valid;
  logic [WIDTH-1:0] data_in;
  logic             load_ready;
  logic             serial_out;
  logic             shift_out;
  logic             busy;
  logic             done;

  modport master (
    output load_valid, data_in,
    input  load_ready, serial_out, shift_out, busy, done
  );

  modport slave (
    input  load_valid, data_in,
    output load_ready, serial_out, shift_out, busy, done
  );
endinterface

// File: rtl/serial_tx.sv
// Parallel-in, serial-out transmitter: MSB-first, DIV cycles per bit, shift_out strobe on each bit's last cycle.
// Optional even-parity trailer bit when SERIAL_TX_PARITY_EN is defined.
module serial_tx #(
  parameter int WIDTH = 4,
  parameter int DIV   = 1
) (
  input  logic        clk,
  input  logic        rst,
  serial_tx_if.slave  bus
);
`ifdef SERIAL_TX_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int BCW = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [NBITS-1:0] r_shreg;
  logic [BCW-1:0]   r_bit_cnt;
  logic [DCW-1:0]   r_div_cnt;

  logic w_strobe;
  logic w_last_bit;

  assign w_strobe   = (r_state == S_SEND) && (r_div_cnt == DCW'(DIV - 1));
  assign w_last_bit = (r_bit_cnt == BCW'(NBITS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_div_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.load_valid) begin
            // Parity rides as the shift register's extra LSB so it leaves last.
`ifdef SERIAL_TX_PARITY_EN
            r_shreg <= {bus.data_in, ^bus.data_in};
`else
            r_shreg <= bus.data_in;
`endif
            r_bit_cnt <= '0;
            r_div_cnt <= '0;
            r_state   <= S_SEND;
          end
        end
        S_SEND: begin
          if (w_strobe) begin
            r_shreg   <= r_shreg << 1;
            r_div_cnt <= '0;
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (w_last_bit) r_state <= S_DONE;
          end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.load_ready = (r_state == S_IDLE);
  assign bus.busy       = (r_state == S_SEND);
  assign bus.done       = (r_state == S_DONE);
  assign bus.serial_out = (r_state == S_SEND) && r_shreg[NBITS-1];
  assign bus.shift_out  = w_strobe;
endmodule

// File: tb/tb_serial_tx.sv
// Randomized scoreboard bench for serial_tx: per-cycle frame model plus a strobe/bit queue and a receiver shift register.
module tb_serial_tx;
  localparam int W    = 4;
  localparam int DIV  = 3;
`ifdef SERIAL_TX_PARITY_EN
  localparam int NB   = W + 1;
`else
  localparam int NB   = W;
`endif
  localparam int FLEN = NB * DIV;
  localparam int MAXC = 4000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_tx_if #(.WIDTH(W)) bus_if ();
  serial_tx #(.WIDTH(W), .DIV(DIV)) dut (.clk(clk), .rst(rst), .bus(bus_if));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int c; logic b; } stb_t;
  typedef struct { int dc; logic [NB-1:0] w; } frm_t;
  stb_t sq[$];
  frm_t fq[$];

  // Expected status per cycle: 0 idle, 1 sending, 2 done.
  logic [1:0] st [MAXC];
  logic       so [MAXC];
  int next_free = 0;
  int checks = 0, errors = 0;

  logic [NB-1:0] rx = '0;
  always @(posedge clk)
    if (bus_if.shift_out === 1'b1) rx <= {rx[NB-2:0], bus_if.serial_out};

  function automatic logic [NB-1:0] frame_of(logic [W-1:0] d);
`ifdef SERIAL_TX_PARITY_EN
    return {d, ^d};
`else
    return d;
`endif
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic drive(bit r, bit lv, logic [W-1:0] d);
    int c;
    c = cyc;
    rst = r;
    bus_if.load_valid = lv;
    bus_if.data_in = d;
    if (r) begin
      for (int t = c + 1; t <= c + FLEN + 1 && t < MAXC; t++) st[t] = 2'd0;
      while (sq.size() > 0 && sq[$].c > c) void'(sq.pop_back());
      while (fq.size() > 0 && fq[$].dc > c) void'(fq.pop_back());
      next_free = c + 1;
    end else if (lv && c >= next_free) begin
      logic [NB-1:0] f;
      stb_t e;
      frm_t fr;
      f = frame_of(d);
      for (int k = 0; k < NB; k++) begin
        for (int t = c + 1 + k * DIV; t <= c + (k + 1) * DIV; t++) begin
          st[t] = 2'd1;
          so[t] = f[NB-1-k];
        end
        e.c = c + (k + 1) * DIV;
        e.b = f[NB-1-k];
        sq.push_back(e);
      end
      st[c + FLEN + 1] = 2'd2;
      fr.dc = c + FLEN + 1;
      fr.w = f;
      fq.push_back(fr);
      next_free = c + FLEN + 2;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0);
  endtask

  logic [1:0] m_s;
  stb_t       m_e;
  frm_t       m_f;
  always @(negedge clk) begin
    if (cyc >= 1 && cyc < MAXC) begin
      m_s = st[cyc];
      chk("load_ready", 32'(bus_if.load_ready), 32'(m_s == 2'd0));
      chk("busy",       32'(bus_if.busy),       32'(m_s == 2'd1));
      chk("done",       32'(bus_if.done),       32'(m_s == 2'd2));
      chk("serial_out", 32'(bus_if.serial_out), 32'((m_s == 2'd1) ? so[cyc] : 1'b0));
      if (bus_if.shift_out !== 1'b0) begin
        if (sq.size() == 0) chk("strobe_unexpected", 32'(bus_if.shift_out), 32'd0);
        else begin
          m_e = sq.pop_front();
          chk("strobe_cycle", 32'(cyc), 32'(m_e.c));
          chk("strobe_bit", 32'(bus_if.serial_out), 32'(m_e.b));
        end
      end
      if (bus_if.done !== 1'b0) begin
        if (fq.size() == 0) chk("done_unexpected", 32'(bus_if.done), 32'd0);
        else begin
          m_f = fq.pop_front();
          chk("rx_word", 32'(rx), 32'(m_f.w));
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < MAXC; i++) begin
      st[i] = 2'd0;
      so[i] = 1'b0;
    end
    // Reset held two cycles with load_valid high; nothing may start afterwards.
    drive(1'b1, 1'b1, 4'b1011);
    drive(1'b1, 1'b1, 4'b1011);
    idle(3);
    // Basic frame, with an ignored load attempt two cycles in.
    drive(1'b0, 1'b1, 4'b1011);
    idle(1);
    drive(1'b0, 1'b1, 4'b1111);
    idle(FLEN + 3);
    drive(1'b0, 1'b1, 4'b0110);
    idle(FLEN + 3);
    // Abort mid-frame, then a clean frame.
    drive(1'b0, 1'b1, 4'b1011);
    idle(1);
    drive(1'b1, 1'b0, '0);
    drive(1'b0, 1'b1, 4'b0101);
    idle(FLEN + 3);
    // rst and load_valid together: rst wins.
    drive(1'b1, 1'b1, 4'b1110);
    idle(4);
    // Back-to-back loads held high.
    for (int i = 0; i < 3 * (FLEN + 2); i++) drive(1'b0, 1'b1, W'($urandom));
    for (int i = 0; i < 700; i++)
      drive($urandom_range(0, 79) == 0, $urandom_range(0, 3) == 0, W'($urandom));
    idle(FLEN + 5);
    chk("strobes_pending", 32'(sq.size()), 32'd0);
    chk("frames_pending",  32'(fq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
